// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scanning 3x4 keypad controller with whole-frame debounce and a valid/ready key output.
// Defining KEYPAD_REPEAT_EN adds auto-repeat of a reported key that stays held.
module keypad_scanner #(
    parameter int SCAN_DIV      = 4,
    parameter int DEBOUNCE      = 3,
    parameter int REPEAT_FRAMES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] col,
    output logic [3:0] row,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [3:0] key_code,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, DEB, REPORT, RELEASE} state_t;
    localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);
    localparam logic [7:0] DEB_N    = 8'(DEBOUNCE);

    if (SCAN_DIV < 2 || DEBOUNCE < 1 || REPEAT_FRAMES < 1) begin : g_bad_param
        $error("keypad_scanner: illegal parameter values");
    end

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d, cnt_q, cnt_d;
    logic [1:0]  ridx_q, ridx_d;
    logic [11:0] smp_q, smp_d;
    logic        fend_q, fend_d, valid_q, valid_d;
    logic [3:0]  cand_q, cand_d, code_q, code_d;
    logic [3:0]  nbits, fcode;
    logic        last, none, single;
`ifdef KEYPAD_REPEAT_EN
    localparam logic [7:0] REP_N = 8'(REPEAT_FRAMES);
    logic [7:0] rcnt_q, rcnt_d;
`endif

    // smp_q holds one frame of column samples: [11:9]=row d {a,b,c} ... [2:0]=row g
    always_comb begin
        last   = div_q == DIV_LAST;
        div_d  = last ? 8'd0 : div_q + 8'd1;
        ridx_d = last ? ridx_q + 2'd1 : ridx_q;
        fend_d = last && ridx_q == 2'd3;
        smp_d  = smp_q;
        for (int r = 0; r < 4; r++)
            if (last && ridx_q == 2'(r)) smp_d[3*(3-r) +: 3] = col;
    end

    always_comb begin
        nbits = '0;
        fcode = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (smp_q[3*(3-r) + 2 - c]) begin
                    nbits = nbits + 4'd1;
                    fcode = 4'(r == 3 ? 0 : 3*r + c + 1);
                end
        none   = nbits == 4'd0;
        single = nbits == 4'd1 && !smp_q[2] && !smp_q[0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        code_d  = code_q;
        valid_d = valid_q;
`ifdef KEYPAD_REPEAT_EN
        rcnt_d  = rcnt_q;
`endif
        case (state_q)
            IDLE: if (fend_q && single) begin
                cand_d = fcode;
                if (DEB_N == 8'd1) begin
                    state_d = REPORT;
                    valid_d = 1'b1;
                    code_d  = fcode;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = DEB;
                    cnt_d   = 8'd1;
                end
            end
            DEB: if (fend_q) begin
                if (single && fcode == cand_q) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == DEB_N) begin
                        state_d = REPORT;
                        valid_d = 1'b1;
                        code_d  = cand_q;
                        cnt_d   = 8'd0;
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
            end
            REPORT: if (valid_q && key_ready) begin
                state_d = RELEASE;
                valid_d = 1'b0;
                cnt_d   = 8'd0;
`ifdef KEYPAD_REPEAT_EN
                rcnt_d  = 8'd0;
`endif
            end
            RELEASE: if (fend_q) begin
                cnt_d = none ? cnt_q + 8'd1 : 8'd0;
                if (cnt_d == DEB_N) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
`ifdef KEYPAD_REPEAT_EN
                rcnt_d = (single && fcode == code_q) ? rcnt_q + 8'd1 : 8'd0;
                if (rcnt_d == REP_N) begin
                    state_d = REPORT;
                    valid_d = 1'b1;
                    rcnt_d  = 8'd0;
                    cnt_d   = 8'd0;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            ridx_q  <= '0;
            smp_q   <= '0;
            fend_q  <= 1'b0;
            cnt_q   <= '0;
            cand_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            ridx_q  <= ridx_d;
            smp_q   <= smp_d;
            fend_q  <= fend_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            valid_q <= valid_d;
`ifdef KEYPAD_REPEAT_EN
            rcnt_q  <= rcnt_d;
`endif
        end
    end

    assign row       = 4'b1000 >> ridx_q;
    assign key_valid = valid_q;
    assign key_code  = code_q;
    assign busy      = state_q != IDLE;
endmodule
